// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the fetch/decode boundary: canonical NOP, default width,
// and the immediate-operand formats decoded from instruction bits [31:7].
package inst_fetch_queue_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_type_e;

   function automatic logic pc_misaligned(input logic [1:0] pc_low);
      return |pc_low;
   endfunction

endpackage

// File: rtl/inst_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port so the head entry is visible right after the write edge.
module inst_queue_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 65,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [PTR_W-1:0]   waddr_i,
   input  logic [WIDTH-1:0]   wdata_i,
   input  logic [PTR_W-1:0]   raddr_i,
   output logic [WIDTH-1:0]   rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling queue of {pc, inst, misalign} entries; presents
// the oldest entry, or a canonical NOP when empty. Flush empties it in one cycle.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [XLEN-1:0]  enq_pc,
   input  logic [XLEN-1:0]  enq_inst,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [XLEN-1:0]  deq_pc,
   output logic [XLEN-1:0]  deq_inst,
   output logic             deq_misalign,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned ENTRY_W = 2 * XLEN + 1;

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               enq_fire, deq_fire, mem_we;
   logic [ENTRY_W-1:0] wr_entry, rd_entry;

   // Handshake outputs come only from the occupancy register.
   assign enq_ready = (count_q != CNT_W'(DEPTH));
   assign deq_valid = (count_q != '0);
   assign enq_fire  = enq_valid && enq_ready;
   assign deq_fire  = deq_valid && deq_ready;
   assign mem_we    = enq_fire && !flush && !rst;

   assign wr_entry = {pc_misaligned(enq_pc[1:0]), enq_pc, enq_inst};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (enq_fire && !deq_fire) count_d = count_q + CNT_W'(1);
         else if (deq_fire && !enq_fire) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   inst_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   // Stale storage is never exposed: an empty queue always reads as a NOP.
   assign deq_inst     = deq_valid ? rd_entry[XLEN-1:0]      : XLEN'(NOP_INST);
   assign deq_pc       = deq_valid ? rd_entry[2*XLEN-1:XLEN] : '0;
   assign deq_misalign = deq_valid ? rd_entry[ENTRY_W-1]     : 1'b0;
   assign count        = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus random stimulus against a queue-based reference model of the
// fetch queue; every cycle the full output set is compared to the model.
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        enq_valid = 1'b0;
   logic        enq_ready;
   logic [31:0] enq_pc = '0;
   logic [31:0] enq_inst = '0;
   logic        deq_valid;
   logic        deq_ready = 1'b0;
   logic [31:0] deq_pc;
   logic [31:0] deq_inst;
   logic        deq_misalign;
   logic [2:0]  count;

   int   total = 0;
   int   bad   = 0;
   ent_t model_q[$];

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .enq_valid    (enq_valid),
      .enq_ready    (enq_ready),
      .enq_pc       (enq_pc),
      .enq_inst     (enq_inst),
      .deq_valid    (deq_valid),
      .deq_ready    (deq_ready),
      .deq_pc       (deq_pc),
      .deq_inst     (deq_inst),
      .deq_misalign (deq_misalign),
      .count        (count)
   );

   task automatic check_all(input string tag);
      logic [2:0]  exp_cnt;
      logic        exp_dv, exp_er, exp_mis;
      logic [31:0] exp_pc, exp_inst;
      exp_cnt = 3'(model_q.size());
      exp_dv  = (model_q.size() != 0);
      exp_er  = (model_q.size() < DEPTH);
      if (model_q.size() == 0) begin
         exp_pc = 32'h0; exp_inst = 32'h0000_0013; exp_mis = 1'b0;
      end else begin
         exp_pc = model_q[0].pc; exp_inst = model_q[0].inst;
         exp_mis = (model_q[0].pc[1:0] != 2'b00);
      end
      total++;
      assert (count === exp_cnt) else begin
         bad++; $error("FAIL %s count obs=%0d exp=%0d", tag, count, exp_cnt);
      end
      total++;
      assert (deq_valid === exp_dv) else begin
         bad++; $error("FAIL %s deq_valid obs=%b exp=%b", tag, deq_valid, exp_dv);
      end
      total++;
      assert (enq_ready === exp_er) else begin
         bad++; $error("FAIL %s enq_ready obs=%b exp=%b", tag, enq_ready, exp_er);
      end
      total++;
      assert (deq_pc === exp_pc) else begin
         bad++; $error("FAIL %s deq_pc obs=%h exp=%h", tag, deq_pc, exp_pc);
      end
      total++;
      assert (deq_inst === exp_inst) else begin
         bad++; $error("FAIL %s deq_inst obs=%h exp=%h", tag, deq_inst, exp_inst);
      end
      total++;
      assert (deq_misalign === exp_mis) else begin
         bad++; $error("FAIL %s deq_misalign obs=%b exp=%b", tag, deq_misalign, exp_mis);
      end
   endtask

   // One clock: drive inputs, step the model across the edge, then compare.
   task automatic cycle(input string tag, input logic r, input logic f,
                        input logic ev, input logic [31:0] pc,
                        input logic [31:0] inst, input logic dr);
      bit e, d;
      rst = r; flush = f; enq_valid = ev; enq_pc = pc; enq_inst = inst; deq_ready = dr;
      e = ev && (model_q.size() < DEPTH);
      d = dr && (model_q.size() != 0);
      @(posedge clk);
      if (r || f) begin
         model_q.delete();
      end else begin
         if (d) void'(model_q.pop_front());
         if (e) model_q.push_back('{pc: pc, inst: inst});
      end
      #1;
      $display("%s: rst=%b flush=%b enq=%b pc=%h inst=%h deq_rdy=%b -> count=%0d dv=%b head_pc=%h head_inst=%h",
               tag, r, f, ev, pc, inst, dr, count, deq_valid, deq_pc, deq_inst);
      check_all(tag);
   endtask

   initial begin
      logic [31:0] pcs   [4];
      logic [31:0] insts [4];
      logic [31:0] rpc;
      pcs   = '{32'h0, 32'h4, 32'h8, 32'hC};
      insts = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};

      // Reset then idle
      cycle("reset0", 1, 0, 0, 0, 0, 0);
      cycle("reset1", 1, 0, 0, 0, 0, 0);
      cycle("idle", 0, 0, 0, 0, 0, 1);

      // Fill, attempt a fifth, then drain
      for (int i = 0; i < 4; i++) cycle("fill", 0, 0, 1, pcs[i], insts[i], 0);
      cycle("fill_over", 0, 0, 1, 32'h10, 32'h0000_0033, 0);
      cycle("full_both", 0, 0, 1, 32'h14, 32'h0000_0033, 1);
      for (int i = 0; i < 4; i++) cycle("drain", 0, 0, 0, 0, 0, 1);
      cycle("drain_empty", 0, 0, 0, 0, 0, 1);

      // Wrap-around with occupancy held at 2
      cycle("wrap_pre", 0, 0, 1, 32'h100, 32'h0010_0093, 0);
      cycle("wrap_pre", 0, 0, 1, 32'h104, 32'h0020_0093, 0);
      for (int i = 0; i < 10; i++)
         cycle("wrap", 0, 0, 1, 32'h108 + 32'(4 * i), 32'h0030_0093 + 32'(i << 20), 1);

      // Flush with simultaneous traffic
      cycle("fl_pre", 0, 0, 1, 32'h200, 32'h1, 1);
      cycle("fl_pre", 0, 0, 1, 32'h204, 32'h2, 0);
      cycle("fl", 0, 1, 1, 32'hDEAD_BEE0, 32'hBAD0_0013, 1);
      cycle("fl_after", 0, 0, 1, 32'h300, 32'h0040_0093, 0);
      cycle("fl_drain", 0, 0, 0, 0, 0, 1);

      // Misaligned PC then aligned PC
      cycle("mis", 0, 0, 1, 32'h102, 32'h0050_0093, 0);
      cycle("mis", 0, 0, 1, 32'h104, 32'h0060_0093, 1);
      cycle("mis", 0, 0, 0, 0, 0, 1);

      // Reset mid-fill
      cycle("rmf", 0, 0, 1, 32'h400, 32'h7, 0);
      cycle("rmf", 0, 0, 1, 32'h404, 32'h8, 0);
      cycle("rmf_rst", 1, 0, 1, 32'h408, 32'h9, 1);
      cycle("rmf_enq", 0, 0, 1, 32'h500, 32'h00A0_0093, 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         rpc = $urandom;
         cycle("rand", ($urandom_range(0, 47) == 0), ($urandom_range(0, 19) == 0),
               1'($urandom), rpc, $urandom, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
